// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchronizer, mid-bit sampling, false-start
// rejection and framing-error detection with a one-cycle valid pulse per byte.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, frame_err_n;
  logic             rx_m, rx_s;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt != CNT_HALF) begin
          cnt_n = cnt + CNT_W'(1);
        end else if (!rx_s) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8 clocks/bit instance plus an odd 5 clocks/bit instance.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  logic       rx5;
  logic [7:0] data5;
  logic       valid5;
  logic       frame_err5;
  logic       busy5;

  int checks   = 0;
  int failures = 0;

  int         ecount = 0;
  int         last_start = 0;
  logic [7:0] vd8[$];
  int         ve8[$];
  int         fe8 = 0;
  int         fe_edge8 = 0;
  int         both8 = 0;
  int         busy_at_valid8 = 0;
  bit         saw_busy8 = 0;
  logic [7:0] vd5[$];
  int         ve5[$];
  int         fe5 = 0;

  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(5)) dut5 (
    .clk(clk), .rst(rst), .rx(rx5),
    .data(data5), .valid(valid5), .frame_err(frame_err5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  always @(negedge clk) begin
    if (valid) begin
      vd8.push_back(data);
      ve8.push_back(ecount);
      if (busy) busy_at_valid8++;
    end
    if (frame_err) begin
      fe8++;
      fe_edge8 = ecount;
    end
    if (valid && frame_err) both8++;
    if (busy) saw_busy8 = 1'b1;
    if (valid5) begin
      vd5.push_back(data5);
      ve5.push_back(ecount);
    end
    if (frame_err5) fe5++;
  end

  task automatic clear_mon();
    vd8.delete();
    ve8.delete();
    fe8 = 0;
    both8 = 0;
    busy_at_valid8 = 0;
    saw_busy8 = 1'b0;
    vd5.delete();
    ve5.delete();
    fe5 = 0;
  endtask

  // Called on a negedge; the following posedge is the first that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb, input bit sel5);
    logic bitv;
    last_start = ecount;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) bitv = 1'b0;
      else if (i == 9) bitv = stop_bit;
      else bitv = b[i-1];
      if (sel5) rx5 = bitv;
      else rx = bitv;
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    rx5 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (busy5 !== 1'b0) begin failures++; $display("FAIL reset_busy5 got=%b exp=0", busy5); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    int         got_edge;
    int         start;
    clear_mon();
    send_frame(8'hA5, 1'b1, 8, 1'b0);
    start = last_start;
    rx = 1'b1;
    repeat (6) @(negedge clk);
    got      = (vd8.size() > 0) ? vd8[0] : 8'hxx;
    got_edge = (ve8.size() > 0) ? ve8[0] : -1;
    checks++;
    if (vd8.size() !== 1) begin failures++; $display("FAIL a5_valid_count got=%0d exp=1", vd8.size()); end
    checks++;
    if (got !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", got); end
    checks++;
    if (got_edge !== start + 79) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", got_edge, start + 79); end
    checks++;
    if (fe8 !== 0) begin failures++; $display("FAIL a5_frame_err got=%0d exp=0", fe8); end
    checks++;
    if (busy_at_valid8 !== 0) begin failures++; $display("FAIL a5_busy_with_valid got=%0d exp=0", busy_at_valid8); end
    checks++;
    if (data !== 8'hA5) begin failures++; $display("FAIL a5_data_held got=%h exp=a5", data); end
  endtask

  task automatic test_back_to_back();
    int e0;
    int e1;
    clear_mon();
    send_frame(8'h00, 1'b1, 8, 1'b0);
    send_frame(8'hFF, 1'b1, 8, 1'b0);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    e0 = (ve8.size() > 0) ? ve8[0] : 0;
    e1 = (ve8.size() > 1) ? ve8[1] : 0;
    checks++;
    if (vd8.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", vd8.size()); end
    checks++;
    if (((vd8.size() > 0) ? vd8[0] : 8'hxx) !== 8'h00) begin failures++; $display("FAIL b2b_first got=%h exp=00", (vd8.size() > 0) ? vd8[0] : 8'hxx); end
    checks++;
    if (((vd8.size() > 1) ? vd8[1] : 8'hxx) !== 8'hFF) begin failures++; $display("FAIL b2b_second got=%h exp=ff", (vd8.size() > 1) ? vd8[1] : 8'hxx); end
    checks++;
    if (e1 - e0 !== 80) begin failures++; $display("FAIL b2b_spacing got=%0d exp=80", e1 - e0); end
    checks++;
    if (fe8 !== 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", fe8); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (saw_busy8 !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy8); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    checks++;
    if (vd8.size() !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vd8.size()); end
    checks++;
    if (fe8 !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe8); end
  endtask

  task automatic test_frame_error();
    int start;
    clear_mon();
    send_frame(8'h3C, 1'b1, 8, 1'b0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (data !== 8'h3C) begin failures++; $display("FAIL fe_pre_data got=%h exp=3c", data); end
    clear_mon();
    send_frame(8'h81, 1'b0, 8, 1'b0);
    start = last_start;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (fe8 !== 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", fe8); end
    checks++;
    if (fe_edge8 !== start + 79) begin failures++; $display("FAIL fe_latency got=%0d exp=%0d", fe_edge8, start + 79); end
    checks++;
    if (vd8.size() !== 0) begin failures++; $display("FAIL fe_valid got=%0d exp=0", vd8.size()); end
    checks++;
    if (data !== 8'h3C) begin failures++; $display("FAIL fe_data_kept got=%h exp=3c", data); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fe_busy_while_low got=%b exp=1", busy); end
    checks++;
    if (both8 !== 0) begin failures++; $display("FAIL fe_pulse_overlap got=%0d exp=0", both8); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL fe_busy_release got=%b exp=0", busy); end
    clear_mon();
    send_frame(8'h5A, 1'b1, 8, 1'b0);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (((vd8.size() == 1) ? vd8[0] : 8'hxx) !== 8'h5A) begin failures++; $display("FAIL fe_recover got=%h exp=5a", (vd8.size() > 0) ? vd8[0] : 8'hxx); end
    checks++;
    if (fe8 !== 0) begin failures++; $display("FAIL fe_recover_err got=%0d exp=0", fe8); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hF0;
    clear_mon();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = b[4];
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++;
    if ({valid, frame_err} !== 2'b00) begin failures++; $display("FAIL midrst_pulses got=%b exp=00", {valid, frame_err}); end
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (vd8.size() + fe8 !== 0) begin failures++; $display("FAIL midrst_aborted_pulses got=%0d exp=0", vd8.size() + fe8); end
    send_frame(8'hC3, 1'b1, 8, 1'b0);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (((vd8.size() == 1) ? vd8[0] : 8'hxx) !== 8'hC3) begin failures++; $display("FAIL midrst_next got=%h exp=c3", (vd8.size() > 0) ? vd8[0] : 8'hxx); end
  endtask

  task automatic test_odd_rate();
    logic [7:0] exp5[6];
    int         start0;
    clear_mon();
    exp5[0] = 8'h01;
    exp5[1] = 8'h80;
    for (int i = 2; i < 6; i++) exp5[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      send_frame(exp5[i], 1'b1, 5, 1'b1);
      if (i == 0) start0 = last_start;
    end
    rx5 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (vd5.size() !== 6) begin failures++; $display("FAIL cpb5_count got=%0d exp=6", vd5.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (((vd5.size() > i) ? vd5[i] : 8'hxx) !== exp5[i]) begin
        failures++;
        $display("FAIL cpb5_byte%0d got=%h exp=%h", i, (vd5.size() > i) ? vd5[i] : 8'hxx, exp5[i]);
      end
    end
    checks++;
    if (((ve5.size() > 0) ? ve5[0] : -1) !== start0 + 50) begin failures++; $display("FAIL cpb5_latency got=%0d exp=%0d", (ve5.size() > 0) ? ve5[0] : -1, start0 + 50); end
    checks++;
    if (fe5 !== 0) begin failures++; $display("FAIL cpb5_frame_err got=%0d exp=0", fe5); end
    checks++;
    if (vd8.size() !== 0) begin failures++; $display("FAIL cpb5_crosstalk got=%0d exp=0", vd8.size()); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rx5 = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_odd_rate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
